if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_if_id_latch.sv | 43 ++++
 rtl/if_stage.sv | 79 +++++++
 tb/tb_if_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
//   WORD_W       : data/address word width
//   NOP_WORD_DEF : default instruction word used for IF/ID bubbles
//   RESET_PC_DEF : default word address loaded into the PC on reset
//   IMEM_IDX_W   : number of imem_addr bits the instruction memory decodes
package if_stage_pkg;

    localparam int          WORD_W       = 32;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          IMEM_IDX_W   = 7;

    // Sequential word-address increment. The 32-bit result drops the carry,
    // so 32'hFFFF_FFFF wraps to 32'h0000_0000.
    function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/if_stage_if_id_latch.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   stall           : hold all outputs
//   flush           : load a bubble; beats stall
//   instr_in, npc_in: fetched word and its PC+1, captured on loading edges
//   instr, npc      : registered instruction and next-PC
//   valid           : 1 when instr is a real fetched instruction
//   load            : combinational, high when the next edge captures instr_in
// Control contract: rst beats flush, flush beats stall, and only an edge
// with rst, flush and stall all low captures new contents.
module if_id_latch
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] npc_in,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] npc,
    output logic              valid,
    output logic              load
);

    assign load = !rst && !flush && !stall;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr <= NOP_WORD;
            npc   <= '0;
            valid <= 1'b0;
        end else if (!stall) begin
            instr <= instr_in;
            npc   <= npc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID register and fetch counter.
// The instruction memory sits outside this block; it sees imem_addr and
// returns imem_data in the same cycle.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   stall         : freezes PC and IF/ID
//   flush         : squashes the instruction being latched into IF/ID
//   pc_src        : redirect; next PC = branch_target (wins over stall)
//   branch_target : redirect word address
//   imem_addr     : word address to instruction memory (equals the PC)
//   imem_data     : instruction word for imem_addr
//   if_id_instr   : registered instruction for decode
//   if_id_npc     : registered PC+1 of that instruction
//   if_id_valid   : registered, 1 = real fetched instruction
//   fetch_count   : number of instructions accepted into IF/ID
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              pc_src,
    input  logic [WORD_W-1:0] branch_target,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    output logic [WORD_W-1:0] if_id_instr,
    output logic [WORD_W-1:0] if_id_npc,
    output logic              if_id_valid,
    output logic [WORD_W-1:0] fetch_count
);

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus1;
    logic              if_id_load;

    assign pc_plus1  = pc_inc(pc);
    assign imem_addr = pc;

    // A redirect is honoured even while stalled so it can never be lost;
    // flushing IF/ID on a redirect is the caller's job, not done here.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (pc_src) begin
            pc <= branch_target;
        end else if (!stall) begin
            pc <= pc_plus1;
        end
    end

    if_id_latch #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_latch (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .instr_in (imem_data),
        .npc_in   (pc_plus1),
        .instr    (if_id_instr),
        .npc      (if_id_npc),
        .valid    (if_id_valid),
        .load     (if_id_load)
    );

    // Counts exactly the edges on which IF/ID captures a new instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (if_id_load) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        pc_src;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    // instruction memory model, optionally overridden to prove that data
    // changes during a stall are ignored
    logic [31:0] mem [128];
    logic        mem_override;
    logic [31:0] override_val;

    assign imem_data = mem_override ? override_val : mem[imem_addr[6:0]];

    int n_compared = 0;
    int n_mismatched = 0;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_npc     (if_id_npc),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        pc_src;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_npc;
        logic        exp_valid;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic f,
                                input logic p, input logic [31:0] t,
                                input logic [31:0] ea, input logic [31:0] ei,
                                input logic [31:0] en, input logic ev,
                                input logic [31:0] ec);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.pc_src = p; v.target = t;
        v.exp_addr = ea; v.exp_instr = ei; v.exp_npc = en;
        v.exp_valid = ev; v.exp_count = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: apply inputs, take one edge, sample 1 time unit later
    task automatic step(input logic r, input logic s, input logic f,
                        input logic p, input logic [31:0] t);
        rst = r; stall = s; flush = f; pc_src = p; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] ea,
                             input logic [31:0] ei, input logic [31:0] en,
                             input logic ev, input logic [31:0] ec);
        check({tag, " imem_addr"}, imem_addr, ea);
        check({tag, " if_id_instr"}, if_id_instr, ei);
        check({tag, " if_id_npc"}, if_id_npc, en);
        check({tag, " if_id_valid"}, {31'd0, if_id_valid}, {31'd0, ev});
        check({tag, " fetch_count"}, fetch_count, ec);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0000;

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
        branch_target = '0; mem_override = 1'b0; override_val = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'h0023_00aa;
        mem[1] = 32'h1025_4321;
        mem[2] = 32'h0020_0022;
        mem[3] = 32'h8c12_3456;

        //              rst stall flush pcsrc target | addr  instr          npc  v  cnt
        // reset, then 4 free-running fetches
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, NOP,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h0023_00aa,  1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  2, 32'h1025_4321,  2, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0,  3, 32'h0020_0022,  3, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  4, 32'h8c12_3456,  4, 1, 4));
        // reset, 3 fetches, stall 2 cycles at PC=3, release
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, NOP,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h0023_00aa,  1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  2, 32'h1025_4321,  2, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0,  3, 32'h0020_0022,  3, 1, 3));
        vecs.push_back(mk(0, 1, 0, 0, 0,  3, 32'h0020_0022,  3, 1, 3));
        vecs.push_back(mk(0, 1, 0, 0, 0,  3, 32'h0020_0022,  3, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  4, 32'h8c12_3456,  4, 1, 4));
        // reset, 2 fetches, redirect to 7 with flush at PC=2
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, NOP,            0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h0023_00aa,  1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  2, 32'h1025_4321,  2, 1, 2));
        vecs.push_back(mk(0, 0, 1, 1, 7,  7, NOP,            0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0,  8, 32'hA000_0007,  8, 1, 3));
        // stall+flush+pc_src to 5, then fetch word 5
        vecs.push_back(mk(0, 1, 1, 1, 5,  5, NOP,            0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  6, 32'hA000_0005,  6, 1, 4));
        // stall at PC=6, then reset while stalled and redirecting
        vecs.push_back(mk(0, 1, 0, 0, 0,  6, 32'hA000_0005,  6, 1, 4));
        vecs.push_back(mk(1, 1, 1, 1, 9,  0, NOP,            0, 0, 0));
        // flush alone: PC still advances, bubble, no count
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h0023_00aa,  1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  2, NOP,            0, 0, 1));
        // stall+flush: PC held, bubble
        vecs.push_back(mk(0, 1, 1, 0, 0,  2, NOP,            0, 0, 1));
        // pc_src during stall: PC redirects, IF/ID held, no self-flush
        vecs.push_back(mk(0, 1, 0, 1, 4,  4, NOP,            0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  5, 32'hA000_0004,  5, 1, 2));
        // branch to current PC: same address reloaded, IF/ID loads normally
        vecs.push_back(mk(0, 0, 0, 1, 5,  5, 32'hA000_0005,  6, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  6, 32'hA000_0005,  6, 1, 4));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].flush,
                 vecs[i].pc_src, vecs[i].target);
            check_all($sformatf("row%0d", i), vecs[i].exp_addr,
                      vecs[i].exp_instr, vecs[i].exp_npc,
                      vecs[i].exp_valid, vecs[i].exp_count);
        end

        // imem_data changing during a stall must not reach IF/ID
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_all("pre_stall", 1, 32'h0023_00aa, 1, 1, 1);
        mem_override = 1'b1;
        override_val = 32'hDEAD_BEEF;
        step(0, 1, 0, 0, 0);
        check_all("stall_data_chg", 1, 32'h0023_00aa, 1, 1, 1);
        override_val = 32'hCAFE_F00D;
        step(0, 1, 0, 0, 0);
        check_all("stall_data_chg2", 1, 32'h0023_00aa, 1, 1, 1);
        mem_override = 1'b0;
        step(0, 0, 0, 0, 0);
        check_all("stall_release", 2, 32'h1025_4321, 2, 1, 2);

        // PC wrap: branch to 32'hFFFF_FFFF, then free-run wraps to 0
        step(0, 0, 1, 1, 32'hFFFF_FFFF);
        check_all("wrap_redirect", 32'hFFFF_FFFF, NOP, 0, 0, 2);
        step(0, 0, 0, 0, 0);
        check_all("wrap_fetch", 0, 32'hA000_007F, 0, 1, 3);
        step(0, 0, 0, 0, 0);
        check_all("after_wrap", 1, 32'h0023_00aa, 1, 1, 4);

        // first cycle after reset release presents RESET_PC, IF/ID empty
        step(1, 0, 0, 0, 0);
        check_all("reset_again", 0, NOP, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
